// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller.
// Carries the decode control bundle through the EX, MEM and WB stage
// registers. From those registers it derives load-use stalls,
// redirect flushes, EX operand forwarding selects, and the qualified
// MEM/WB enables. It also keeps saturating stall and flush counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      idRegisterWriteEnable,
  input  logic                      idMemoryReadEnable,
  input  logic                      idMemoryWriteEnable,
  input  logic                      idWriteBackFromMemory,
  input  logic                      idUseRs1,
  input  logic                      idUseRs2,
  input  logic [REG_ADDR_WIDTH-1:0] idRs1,
  input  logic [REG_ADDR_WIDTH-1:0] idRs2,
  input  logic [REG_ADDR_WIDTH-1:0] idRd,
  input  logic                      exRedirect,
  output logic                      pcWriteEnable,
  output logic                      ifIdWriteEnable,
  output logic                      ifIdFlush,
  output logic [1:0]                forwardA,
  output logic [1:0]                forwardB,
  output logic                      memReadEnable,
  output logic                      memWriteEnable,
  output logic                      wbRegisterWriteEnable,
  output logic [REG_ADDR_WIDTH-1:0] wbRd,
  output logic                      wbFromMemory,
  output logic [COUNT_WIDTH-1:0]    stallCount,
  output logic [COUNT_WIDTH-1:0]    flushCount
);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  // Saturating increment: an all-ones counter holds rather than wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    if (&value) begin
      return value;
    end
    return value + COUNT_ONE;
  endfunction

  // True when a producing stage writes the register an EX operand reads.
  // Writes to x0 never forward.
  function automatic logic fwd_hit(
    input logic                      stage_valid,
    input logic                      stage_reg_write,
    input logic [REG_ADDR_WIDTH-1:0] stage_rd,
    input logic [REG_ADDR_WIDTH-1:0] src_reg,
    input logic                      src_used
  );
    return stage_valid & stage_reg_write & (stage_rd != '0) &
           (stage_rd == src_reg) & src_used;
  endfunction

  // The MEM result is younger than the WB result, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FWD_MEM;
    end
    if (wb_hit) begin
      return FWD_WB;
    end
    return FWD_REGFILE;
  endfunction

  // EX stage register
  logic                      ex_valid_q, ex_valid_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_q, ex_rs2_d;
  logic                      ex_use_rs1_q, ex_use_rs1_d;
  logic                      ex_use_rs2_q, ex_use_rs2_d;
  logic                      ex_reg_write_q, ex_reg_write_d;
  logic                      ex_mem_read_q, ex_mem_read_d;
  logic                      ex_mem_write_q, ex_mem_write_d;
  logic                      ex_wb_from_mem_q, ex_wb_from_mem_d;

  // MEM stage register
  logic                      mem_valid_q, mem_valid_d;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_q, mem_rd_d;
  logic                      mem_reg_write_q, mem_reg_write_d;
  logic                      mem_mem_read_q, mem_mem_read_d;
  logic                      mem_mem_write_q, mem_mem_write_d;
  logic                      mem_wb_from_mem_q, mem_wb_from_mem_d;

  // WB stage register
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic                      wb_reg_write_q, wb_reg_write_d;
  logic                      wb_mem_read_q, wb_mem_read_d;
  logic                      wb_mem_write_q, wb_mem_write_d;
  logic                      wb_wb_from_mem_q, wb_wb_from_mem_d;

  // Performance counters
  logic [COUNT_WIDTH-1:0]    stall_count_q, stall_count_d;
  logic [COUNT_WIDTH-1:0]    flush_count_q, flush_count_d;

  logic                      load_use;
  logic                      stall;
  logic                      rs1_mem_hit, rs1_wb_hit;
  logic                      rs2_mem_hit, rs2_wb_hit;

  // Hazard detection: a load in EX whose rd is read by the decode
  // instruction needs one bubble. A redirect kills the decode
  // instruction, so it cancels the stall.
  always_comb begin
    load_use = ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
               ((idUseRs1 & (idRs1 == ex_rd_q)) |
                (idUseRs2 & (idRs2 == ex_rd_q)));
    stall    = load_use & ~exRedirect;
  end

  // Front-end control. The flush is masked while in reset so that the
  // outputs show an idle pipeline.
  always_comb begin
    pcWriteEnable   = ~stall;
    ifIdWriteEnable = ~stall;
    ifIdFlush       = exRedirect & rstN;
  end

  // Operand forwarding for the instruction currently in EX
  always_comb begin
    rs1_mem_hit = fwd_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_rs1_q, ex_use_rs1_q);
    rs1_wb_hit  = fwd_hit(wb_valid_q,  wb_reg_write_q,  wb_rd_q,  ex_rs1_q, ex_use_rs1_q);
    rs2_mem_hit = fwd_hit(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_rs2_q, ex_use_rs2_q);
    rs2_wb_hit  = fwd_hit(wb_valid_q,  wb_reg_write_q,  wb_rd_q,  ex_rs2_q, ex_use_rs2_q);
    forwardA    = fwd_select(rs1_mem_hit, rs1_wb_hit);
    forwardB    = fwd_select(rs2_mem_hit, rs2_wb_hit);
  end

  // Qualified MEM and WB stage outputs
  always_comb begin
    memReadEnable         = mem_valid_q & mem_mem_read_q;
    memWriteEnable        = mem_valid_q & mem_mem_write_q;
    wbRegisterWriteEnable = wb_valid_q & wb_reg_write_q & (wb_rd_q != '0);
    wbRd                  = wb_rd_q;
    wbFromMemory          = wb_wb_from_mem_q;
    stallCount            = stall_count_q;
    flushCount            = flush_count_q;
  end

  // EX next state: a bubble on a redirect or a stall, otherwise the
  // decoded instruction.
  always_comb begin
    ex_valid_d       = 1'b0;
    ex_rd_d          = '0;
    ex_rs1_d         = '0;
    ex_rs2_d         = '0;
    ex_use_rs1_d     = 1'b0;
    ex_use_rs2_d     = 1'b0;
    ex_reg_write_d   = 1'b0;
    ex_mem_read_d    = 1'b0;
    ex_mem_write_d   = 1'b0;
    ex_wb_from_mem_d = 1'b0;
    if (!exRedirect && !load_use) begin
      ex_valid_d       = 1'b1;
      ex_rd_d          = idRd;
      ex_rs1_d         = idRs1;
      ex_rs2_d         = idRs2;
      ex_use_rs1_d     = idUseRs1;
      ex_use_rs2_d     = idUseRs2;
      ex_reg_write_d   = idRegisterWriteEnable;
      ex_mem_read_d    = idMemoryReadEnable;
      ex_mem_write_d   = idMemoryWriteEnable;
      ex_wb_from_mem_d = idWriteBackFromMemory;
    end
  end

  // MEM and WB next state: they advance every cycle with no back-pressure
  always_comb begin
    mem_valid_d       = ex_valid_q;
    mem_rd_d          = ex_rd_q;
    mem_reg_write_d   = ex_reg_write_q;
    mem_mem_read_d    = ex_mem_read_q;
    mem_mem_write_d   = ex_mem_write_q;
    mem_wb_from_mem_d = ex_wb_from_mem_q;
    wb_valid_d        = mem_valid_q;
    wb_rd_d           = mem_rd_q;
    wb_reg_write_d    = mem_reg_write_q;
    wb_mem_read_d     = mem_mem_read_q;
    wb_mem_write_d    = mem_mem_write_q;
    wb_wb_from_mem_d  = mem_wb_from_mem_q;
  end

  // Counter next state: a redirect counts as a flush; a stall is counted
  // only when it was not overridden by the redirect.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (exRedirect) begin
      flush_count_d = sat_inc(flush_count_q);
    end else if (load_use) begin
      stall_count_d = sat_inc(stall_count_q);
    end
  end

  // Stage registers and counters, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ex_valid_q        <= 1'b0;
      ex_rd_q           <= '0;
      ex_rs1_q          <= '0;
      ex_rs2_q          <= '0;
      ex_use_rs1_q      <= 1'b0;
      ex_use_rs2_q      <= 1'b0;
      ex_reg_write_q    <= 1'b0;
      ex_mem_read_q     <= 1'b0;
      ex_mem_write_q    <= 1'b0;
      ex_wb_from_mem_q  <= 1'b0;
      mem_valid_q       <= 1'b0;
      mem_rd_q          <= '0;
      mem_reg_write_q   <= 1'b0;
      mem_mem_read_q    <= 1'b0;
      mem_mem_write_q   <= 1'b0;
      mem_wb_from_mem_q <= 1'b0;
      wb_valid_q        <= 1'b0;
      wb_rd_q           <= '0;
      wb_reg_write_q    <= 1'b0;
      wb_mem_read_q     <= 1'b0;
      wb_mem_write_q    <= 1'b0;
      wb_wb_from_mem_q  <= 1'b0;
      stall_count_q     <= '0;
      flush_count_q     <= '0;
    end else begin
      ex_valid_q        <= ex_valid_d;
      ex_rd_q           <= ex_rd_d;
      ex_rs1_q          <= ex_rs1_d;
      ex_rs2_q          <= ex_rs2_d;
      ex_use_rs1_q      <= ex_use_rs1_d;
      ex_use_rs2_q      <= ex_use_rs2_d;
      ex_reg_write_q    <= ex_reg_write_d;
      ex_mem_read_q     <= ex_mem_read_d;
      ex_mem_write_q    <= ex_mem_write_d;
      ex_wb_from_mem_q  <= ex_wb_from_mem_d;
      mem_valid_q       <= mem_valid_d;
      mem_rd_q          <= mem_rd_d;
      mem_reg_write_q   <= mem_reg_write_d;
      mem_mem_read_q    <= mem_mem_read_d;
      mem_mem_write_q   <= mem_mem_write_d;
      mem_wb_from_mem_q <= mem_wb_from_mem_d;
      wb_valid_q        <= wb_valid_d;
      wb_rd_q           <= wb_rd_d;
      wb_reg_write_q    <= wb_reg_write_d;
      wb_mem_read_q     <= wb_mem_read_d;
      wb_mem_write_q    <= wb_mem_write_d;
      wb_wb_from_mem_q  <= wb_wb_from_mem_d;
      stall_count_q     <= stall_count_d;
      flush_count_q     <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Testbench for pipeline_hazard_controller: directed hazard sequences
// plus a random instruction stream, checked against a scoreboard of
// expected outputs.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        rstN;
  logic        idRegisterWriteEnable, idMemoryReadEnable, idMemoryWriteEnable;
  logic        idWriteBackFromMemory, idUseRs1, idUseRs2;
  logic [4:0]  idRs1, idRs2, idRd;
  logic        exRedirect;
  logic        pcWriteEnable, ifIdWriteEnable, ifIdFlush;
  logic [1:0]  forwardA, forwardB;
  logic        memReadEnable, memWriteEnable, wbRegisterWriteEnable;
  logic [4:0]  wbRd;
  logic        wbFromMemory;
  logic [15:0] stallCount, flushCount;

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rstN(rstN),
    .idRegisterWriteEnable(idRegisterWriteEnable),
    .idMemoryReadEnable(idMemoryReadEnable),
    .idMemoryWriteEnable(idMemoryWriteEnable),
    .idWriteBackFromMemory(idWriteBackFromMemory),
    .idUseRs1(idUseRs1), .idUseRs2(idUseRs2),
    .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
    .exRedirect(exRedirect),
    .pcWriteEnable(pcWriteEnable), .ifIdWriteEnable(ifIdWriteEnable),
    .ifIdFlush(ifIdFlush), .forwardA(forwardA), .forwardB(forwardB),
    .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .wbRegisterWriteEnable(wbRegisterWriteEnable), .wbRd(wbRd),
    .wbFromMemory(wbFromMemory), .stallCount(stallCount), .flushCount(flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw, mr, mw, wfm, u1, u2;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  typedef struct packed {
    logic       v, rw, mr, mw, wfm, u1, u2;
    logic [4:0] rd, rs1, rs2;
  } stage_t;

  typedef struct packed {
    logic        pcwe, ifwe, flush;
    logic [1:0]  fa, fb;
    logic        mre, mwe, wbwe;
    logic [4:0]  wbrd;
    logic        wbfm;
    logic [15:0] sc, fc;
  } exp_t;

  exp_t        sb[$];
  stage_t      st[3];
  logic [15:0] m_stall, m_flush;
  int          errors = 0;
  int          checks = 0;

  logic [1:0]  obs_fa, obs_fb;
  logic        obs_pcwe, obs_wbwe;
  logic [15:0] obs_sc, obs_fc;
  int          obs_stall_cycles;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic rw, mr, mw, wfm, u1, u2,
                                input logic [4:0] rs1, rs2, rd);
    instr_t i;
    i.rw = rw; i.mr = mr; i.mw = mw; i.wfm = wfm; i.u1 = u1; i.u2 = u2;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    return i;
  endfunction

  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] base);
    return mk(1, 1, 0, 1, 1, 0, base, 5'd0, rd);
  endfunction
  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return mk(1, 0, 0, 0, 1, 1, a, b, rd);
  endfunction
  function automatic instr_t addi(input logic [4:0] rd, input logic [4:0] a);
    return mk(1, 0, 0, 0, 1, 0, a, 5'd0, rd);
  endfunction
  function automatic instr_t sw(input logic [4:0] base, input logic [4:0] src);
    return mk(0, 0, 1, 0, 1, 1, base, src, 5'd0);
  endfunction
  function automatic instr_t nop();
    return mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endfunction

  function automatic logic [15:0] m_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reference forwarding: scan WB then MEM so a MEM match overrides.
  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic use_it);
    logic [1:0] sel;
    sel = 2'b00;
    for (int s = 2; s >= 1; s--) begin
      if (use_it && st[s].v && st[s].rw && st[s].rd != 5'd0 && st[s].rd == rs)
        sel = (s == 1) ? 2'b10 : 2'b01;
    end
    return sel;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 3; s++) st[s] = '0;
    m_stall = 16'd0;
    m_flush = 16'd0;
  endtask

  task automatic drive(input instr_t ins, input logic redir);
    idRegisterWriteEnable = ins.rw;  idMemoryReadEnable = ins.mr;
    idMemoryWriteEnable   = ins.mw;  idWriteBackFromMemory = ins.wfm;
    idUseRs1 = ins.u1; idUseRs2 = ins.u2;
    idRs1 = ins.rs1;   idRs2 = ins.rs2; idRd = ins.rd;
    exRedirect = redir;
  endtask

  // One clock of stimulus: drive, predict, compare at negedge, advance model.
  task automatic step(input instr_t ins, input logic redir, output logic stalled);
    exp_t e, g;
    logic lu;
    drive(ins, redir);
    lu = st[0].v && st[0].mr && st[0].rd != 5'd0 &&
         ((ins.u1 && ins.rs1 == st[0].rd) || (ins.u2 && ins.rs2 == st[0].rd));
    stalled = lu && !redir;
    e.pcwe  = !stalled;
    e.ifwe  = !stalled;
    e.flush = redir;
    e.fa    = m_fwd(st[0].rs1, st[0].u1);
    e.fb    = m_fwd(st[0].rs2, st[0].u2);
    e.mre   = st[1].v && st[1].mr;
    e.mwe   = st[1].v && st[1].mw;
    e.wbwe  = st[2].v && st[2].rw && st[2].rd != 5'd0;
    e.wbrd  = st[2].rd;
    e.wbfm  = st[2].wfm;
    e.sc    = m_stall;
    e.fc    = m_flush;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    check_eq("pcWriteEnable", {31'd0, pcWriteEnable}, {31'd0, g.pcwe});
    check_eq("ifIdWriteEnable", {31'd0, ifIdWriteEnable}, {31'd0, g.ifwe});
    check_eq("ifIdFlush", {31'd0, ifIdFlush}, {31'd0, g.flush});
    check_eq("forwardA", {30'd0, forwardA}, {30'd0, g.fa});
    check_eq("forwardB", {30'd0, forwardB}, {30'd0, g.fb});
    check_eq("memReadEnable", {31'd0, memReadEnable}, {31'd0, g.mre});
    check_eq("memWriteEnable", {31'd0, memWriteEnable}, {31'd0, g.mwe});
    check_eq("wbRegisterWriteEnable", {31'd0, wbRegisterWriteEnable}, {31'd0, g.wbwe});
    check_eq("wbRd", {27'd0, wbRd}, {27'd0, g.wbrd});
    check_eq("wbFromMemory", {31'd0, wbFromMemory}, {31'd0, g.wbfm});
    check_eq("stallCount", {16'd0, stallCount}, {16'd0, g.sc});
    check_eq("flushCount", {16'd0, flushCount}, {16'd0, g.fc});
    obs_fa = forwardA; obs_fb = forwardB; obs_pcwe = pcWriteEnable;
    obs_wbwe = wbRegisterWriteEnable; obs_sc = stallCount; obs_fc = flushCount;
    if (!pcWriteEnable) obs_stall_cycles++;
    @(posedge clk);
    st[2] = st[1];
    st[1] = st[0];
    if (redir) begin
      st[0] = '0;
      m_flush = m_inc(m_flush);
    end else if (stalled) begin
      st[0] = '0;
      m_stall = m_inc(m_stall);
    end else begin
      st[0].v = 1'b1;  st[0].rw = ins.rw; st[0].mr = ins.mr; st[0].mw = ins.mw;
      st[0].wfm = ins.wfm; st[0].u1 = ins.u1; st[0].u2 = ins.u2;
      st[0].rd = ins.rd; st[0].rs1 = ins.rs1; st[0].rs2 = ins.rs2;
    end
    #1;
  endtask

  // Issue one instruction, re-presenting it while decode is held.
  task automatic send(input instr_t ins);
    logic s;
    int   n;
    n = 0;
    do begin
      step(ins, 1'b0, s);
      n++;
    end while (s && n < 4);
    check_eq("stall_bound", {31'd0, s}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pcwe"}, {31'd0, pcWriteEnable}, 32'd1);
    check_eq({tag, "_ifwe"}, {31'd0, ifIdWriteEnable}, 32'd1);
    check_eq({tag, "_flush"}, {31'd0, ifIdFlush}, 32'd0);
    check_eq({tag, "_fa"}, {30'd0, forwardA}, 32'd0);
    check_eq({tag, "_fb"}, {30'd0, forwardB}, 32'd0);
    check_eq({tag, "_mre"}, {31'd0, memReadEnable}, 32'd0);
    check_eq({tag, "_mwe"}, {31'd0, memWriteEnable}, 32'd0);
    check_eq({tag, "_wbwe"}, {31'd0, wbRegisterWriteEnable}, 32'd0);
    check_eq({tag, "_wbrd"}, {27'd0, wbRd}, 32'd0);
    check_eq({tag, "_sc"}, {16'd0, stallCount}, 32'd0);
    check_eq({tag, "_fc"}, {16'd0, flushCount}, 32'd0);
  endtask

  function automatic instr_t rnd_instr();
    logic [4:0] a, b, d;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0:       return lw(d, a);
      1:       return sw(a, b);
      2:       return addi(d, a);
      3:       return nop();
      default: return alu(d, a, b);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    rstN = 1'b0;
    obs_stall_cycles = 0;
    drive(nop(), 1'b1);
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    drive(nop(), 1'b0);
    rstN = 1'b1;

    // Load-use: lw x5 ; add x6,x5,x1 -> one stall, then WB forward
    send(lw(5'd5, 5'd1));
    obs_stall_cycles = 0;
    send(alu(5'd6, 5'd5, 5'd1));
    check_eq("lu_stall_cycles", obs_stall_cycles, 32'd1);
    send(nop());
    check_eq("lu_fwdA_wb", {30'd0, obs_fa}, 32'd1);
    check_eq("lu_stallcount", {16'd0, obs_sc}, 32'd1);

    // add x3 ; add x3 ; add x4,x3,x3 -> MEM priority
    send(alu(5'd3, 5'd1, 5'd2));
    send(alu(5'd3, 5'd2, 5'd1));
    send(alu(5'd4, 5'd3, 5'd3));
    send(nop());
    check_eq("fwd_mem_prio_a", {30'd0, obs_fa}, 32'd2);
    check_eq("fwd_mem_prio_b", {30'd0, obs_fb}, 32'd2);
    // add x3 ; nop ; add x4,x3,x3 -> WB forward
    send(alu(5'd3, 5'd1, 5'd2));
    send(nop());
    send(alu(5'd4, 5'd3, 5'd3));
    send(nop());
    check_eq("fwd_wb_a", {30'd0, obs_fa}, 32'd1);
    check_eq("fwd_wb_b", {30'd0, obs_fb}, 32'd1);

    // x0 never forwards nor writes back
    send(addi(5'd0, 5'd0));
    send(alu(5'd7, 5'd0, 5'd0));
    send(nop());
    check_eq("x0_fwdA", {30'd0, obs_fa}, 32'd0);
    send(nop());
    check_eq("x0_wbwe", {31'd0, obs_wbwe}, 32'd0);

    // Redirect while decode matches a load in EX
    send(lw(5'd9, 5'd1));
    step(alu(5'd10, 5'd9, 5'd9), 1'b1, s);
    check_eq("redir_no_stall", {31'd0, obs_pcwe}, 32'd1);
    send(nop());
    check_eq("redir_flushcount", {16'd0, obs_fc}, 32'd1);
    check_eq("redir_stallcount", {16'd0, obs_sc}, 32'd1);

    // Stall counter saturation
    send(lw(5'd5, 5'd1));
    force dut.stall_count_q = 16'hFFFF;
    #1;
    release dut.stall_count_q;
    m_stall = 16'hFFFF;
    send(alu(5'd6, 5'd5, 5'd0));
    send(nop());
    check_eq("stall_saturate", {16'd0, obs_sc}, 32'h0000FFFF);

    // Random stream with occasional redirects
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) step(rnd_instr(), 1'b1, s);
      else send(rnd_instr());
    end

    // Asynchronous reset in the middle of a load-use stall
    send(lw(5'd5, 5'd2));
    drive(alu(5'd6, 5'd5, 5'd5), 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    m_reset();
    exRedirect = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step(alu(5'd6, 5'd5, 5'd5), 1'b0, s);
    check_eq("post_reset_no_stall", {31'd0, obs_pcwe}, 32'd1);
    for (int i = 0; i < 40; i++) send(rnd_instr());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
